// File: rtl/uart_point_decoder.sv
// Assembles 8-byte vector-point frames from the uart_rx byte stream and
// presents checksum-validated points on a one-entry valid/ready holding register.
module uart_point_decoder #(
  parameter logic [7:0] SYNC_BYTE    = 8'hA5,
  parameter int         TIMEOUT_CLKS = 2000,
  parameter int         CNT_W        = 16
) (
  input  logic             i_Clock,
  input  logic             i_Rst_L,
  input  logic             i_Rx_DV,
  input  logic [7:0]       i_Rx_Byte,
  output logic             o_Pt_Valid,
  input  logic             i_Pt_Ready,
  output logic [11:0]      o_Pt_X,
  output logic [11:0]      o_Pt_Y,
  output logic [7:0]       o_Pt_R,
  output logic [7:0]       o_Pt_G,
  output logic [7:0]       o_Pt_B,
  output logic             o_Frame_Err,
  output logic             o_Overflow,
  output logic [CNT_W-1:0] o_Frame_Count
);

  localparam int TO_W = $clog2(TIMEOUT_CLKS);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CLKS - 1);

  typedef enum logic [1:0] {HUNT, PAYLOAD, CHECK} state_t;

  state_t          state;
  logic [2:0]      idx;
  logic [7:0]      acc;
  logic [TO_W-1:0] to_cnt;
  logic [11:0]     sh_x;
  logic [11:0]     sh_y;
  logic [7:0]      sh_r;
  logic [7:0]      sh_g;
  logic [7:0]      sh_b;

  logic accept;
  logic timeout;

  assign accept  = o_Pt_Valid & i_Pt_Ready;
  // A byte arriving on the last permitted clock beats the timeout.
  assign timeout = (state != HUNT) && !i_Rx_DV && (to_cnt == TO_LAST);

  always_ff @(posedge i_Clock) begin
    if (!i_Rst_L) begin
      state         <= HUNT;
      idx           <= 3'd0;
      acc           <= 8'h00;
      to_cnt        <= '0;
      sh_x          <= 12'h000;
      sh_y          <= 12'h000;
      sh_r          <= 8'h00;
      sh_g          <= 8'h00;
      sh_b          <= 8'h00;
      o_Pt_Valid    <= 1'b0;
      o_Pt_X        <= 12'h000;
      o_Pt_Y        <= 12'h000;
      o_Pt_R        <= 8'h00;
      o_Pt_G        <= 8'h00;
      o_Pt_B        <= 8'h00;
      o_Frame_Err   <= 1'b0;
      o_Overflow    <= 1'b0;
      o_Frame_Count <= '0;
    end else begin
      // NOTE: pulse defaults first; a later non-blocking assignment in this
      // block overrides them, so each pulse lasts exactly one cycle.
      o_Frame_Err <= 1'b0;
      o_Overflow  <= 1'b0;
      if (accept) o_Pt_Valid <= 1'b0;

      if (i_Rx_DV || state == HUNT) to_cnt <= '0;
      else                          to_cnt <= to_cnt + TO_W'(1);

      case (state)
        HUNT: begin
          if (i_Rx_DV && i_Rx_Byte == SYNC_BYTE) begin
            state <= PAYLOAD;
            idx   <= 3'd1;
            acc   <= 8'h00;
          end
        end

        PAYLOAD: begin
          if (i_Rx_DV) begin
            acc <= acc ^ i_Rx_Byte;
            idx <= idx + 3'd1;
            case (idx)
              3'd1:    sh_x[11:4] <= i_Rx_Byte;
              3'd2:    {sh_x[3:0], sh_y[11:8]} <= i_Rx_Byte;
              3'd3:    sh_y[7:0] <= i_Rx_Byte;
              3'd4:    sh_r <= i_Rx_Byte;
              3'd5:    sh_g <= i_Rx_Byte;
              default: sh_b <= i_Rx_Byte;
            endcase
            if (idx == 3'd6) state <= CHECK;
          end else if (timeout) begin
            o_Frame_Err <= 1'b1;
            state       <= HUNT;
          end
        end

        CHECK: begin
          if (i_Rx_DV) begin
            state <= HUNT;
            if (i_Rx_Byte == acc) begin
              // The slot is free if empty or being drained on this very edge.
              if (!o_Pt_Valid || accept) begin
                o_Pt_Valid    <= 1'b1;
                o_Pt_X        <= sh_x;
                o_Pt_Y        <= sh_y;
                o_Pt_R        <= sh_r;
                o_Pt_G        <= sh_g;
                o_Pt_B        <= sh_b;
                o_Frame_Count <= o_Frame_Count + CNT_W'(1);
              end else begin
                o_Overflow <= 1'b1;
              end
            end else begin
              o_Frame_Err <= 1'b1;
            end
          end else if (timeout) begin
            o_Frame_Err <= 1'b1;
            state       <= HUNT;
          end
        end

        default: state <= HUNT;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_point_decoder.sv
// Directed bench for uart_point_decoder: a queue of expected points is filled as
// frames are sent and drained whenever the DUT hands a point off.
module tb_uart_point_decoder;

  localparam int         T     = 20;
  localparam int         CW    = 16;
  localparam logic [7:0] SYNC  = 8'hA5;

  typedef struct packed {
    logic [11:0] x;
    logic [11:0] y;
    logic [7:0]  r;
    logic [7:0]  g;
    logic [7:0]  b;
  } point_t;

  logic          i_Clock = 1'b0;
  logic          i_Rst_L;
  logic          i_Rx_DV;
  logic [7:0]    i_Rx_Byte;
  logic          i_Pt_Ready;
  logic          o_Pt_Valid;
  logic [11:0]   o_Pt_X;
  logic [11:0]   o_Pt_Y;
  logic [7:0]    o_Pt_R;
  logic [7:0]    o_Pt_G;
  logic [7:0]    o_Pt_B;
  logic          o_Frame_Err;
  logic          o_Overflow;
  logic [CW-1:0] o_Frame_Count;

  int     checks   = 0;
  int     errors   = 0;
  int     err_seen = 0;
  int     ovf_seen = 0;
  point_t sb[$];

  uart_point_decoder #(
    .SYNC_BYTE    (SYNC),
    .TIMEOUT_CLKS (T),
    .CNT_W        (CW)
  ) dut (
    .i_Clock       (i_Clock),
    .i_Rst_L       (i_Rst_L),
    .i_Rx_DV       (i_Rx_DV),
    .i_Rx_Byte     (i_Rx_Byte),
    .o_Pt_Valid    (o_Pt_Valid),
    .i_Pt_Ready    (i_Pt_Ready),
    .o_Pt_X        (o_Pt_X),
    .o_Pt_Y        (o_Pt_Y),
    .o_Pt_R        (o_Pt_R),
    .o_Pt_G        (o_Pt_G),
    .o_Pt_B        (o_Pt_B),
    .o_Frame_Err   (o_Frame_Err),
    .o_Overflow    (o_Overflow),
    .o_Frame_Count (o_Frame_Count)
  );

  always #5 i_Clock = ~i_Clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitor: counts pulses and scores every handshake against the queue.
  always @(negedge i_Clock) begin
    if (i_Rst_L) begin
      if (o_Frame_Err) err_seen++;
      if (o_Overflow)  ovf_seen++;
      if (o_Frame_Err || o_Overflow)
        check("err_ovf_exclusive", 32'(o_Frame_Err & o_Overflow), 32'd0);
      if (o_Pt_Valid && i_Pt_Ready) begin
        check("pt_expected", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
          point_t p;
          p = sb.pop_front();
          check("pt_x", 32'(o_Pt_X), 32'(p.x));
          check("pt_y", 32'(o_Pt_Y), 32'(p.y));
          check("pt_r", 32'(o_Pt_R), 32'(p.r));
          check("pt_g", 32'(o_Pt_G), 32'(p.g));
          check("pt_b", 32'(o_Pt_B), 32'(p.b));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge i_Clock);
    #1;
  endtask

  // One strobe followed by one idle clock: strobes land two clocks apart.
  task automatic send_byte(input logic [7:0] b);
    i_Rx_Byte = b;
    i_Rx_DV   = 1'b1;
    tick();
    i_Rx_DV   = 1'b0;
    tick();
  endtask

  function automatic logic [55:0] frame_head(input point_t p);
    return {SYNC, p.x[11:4], p.x[3:0], p.y[11:8], p.y[7:0], p.r, p.g, p.b};
  endfunction

  function automatic logic [7:0] frame_cs(input point_t p);
    return p.x[11:4] ^ {p.x[3:0], p.y[11:8]} ^ p.y[7:0] ^ p.r ^ p.g ^ p.b;
  endfunction

  // Sends sync + payload; after byte gap_idx inserts gap extra idle clocks.
  task automatic send_head(input point_t p, input int gap_idx, input int gap);
    logic [55:0] h;
    h = frame_head(p);
    for (int i = 0; i < 7; i++) begin
      send_byte(h[55-8*i -: 8]);
      if (i == gap_idx) repeat (gap) tick();
    end
  endtask

  task automatic send_frame(input point_t p, input bit bad, input int gap_idx,
                            input int gap, input bit rdy_cs);
    send_head(p, gap_idx, gap);
    i_Rx_Byte = frame_cs(p) ^ {7'd0, bad};
    i_Rx_DV   = 1'b1;
    if (rdy_cs) i_Pt_Ready = 1'b1;
    tick();
    i_Rx_DV = 1'b0;
    if (rdy_cs) i_Pt_Ready = 1'b0;
    tick();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, 32'(o_Pt_Valid), 32'd0);
    check({tag, "_x"},     32'(o_Pt_X), 32'd0);
    check({tag, "_y"},     32'(o_Pt_Y), 32'd0);
    check({tag, "_rgb"},   32'({o_Pt_R, o_Pt_G, o_Pt_B}), 32'd0);
    check({tag, "_err"},   32'(o_Frame_Err), 32'd0);
    check({tag, "_ovf"},   32'(o_Overflow), 32'd0);
    check({tag, "_count"}, 32'(o_Frame_Count), 32'd0);
  endtask

  initial begin
    point_t p1, p2, p3, p4, p5, p6, p7, p8, p9, p10;
    int e0, o0;
    p1  = '{x:12'h123, y:12'h456, r:8'hFF, g:8'h80, b:8'h01};
    p2  = '{x:12'hA5A, y:12'h5A5, r:8'hA5, g:8'h00, b:8'h33};
    p3  = '{x:12'h000, y:12'hFFF, r:8'h10, g:8'h20, b:8'h30};
    p4  = '{x:12'h7FF, y:12'h800, r:8'h01, g:8'h02, b:8'h04};
    p5  = '{x:12'hABC, y:12'hDEF, r:8'h11, g:8'h22, b:8'h33};
    p6  = '{x:12'h001, y:12'hFFF, r:8'h01, g:8'h02, b:8'h03};
    p7  = '{x:12'hFFF, y:12'h000, r:8'hC0, g:8'hDE, b:8'hEE};
    p8  = '{x:12'h321, y:12'h654, r:8'h0A, g:8'h0B, b:8'h0C};
    p9  = '{x:12'h2B4, y:12'h1E7, r:8'h55, g:8'hAA, b:8'h5A};
    p10 = '{x:12'h0F0, y:12'h0F0, r:8'h99, g:8'h88, b:8'h77};

    i_Rst_L = 1'b0; i_Rx_DV = 1'b0; i_Rx_Byte = 8'h00; i_Pt_Ready = 1'b0;
    repeat (3) tick();
    check_all_zero("reset");
    i_Rst_L = 1'b1;
    tick();

    // Good frame A5 12 34 56 FF 80 01 0E; point visible the clock after the 0E strobe.
    check("cs_vector", 32'(frame_cs(p1)), 32'h0E);
    i_Pt_Ready = 1'b1;
    sb.push_back(p1);
    send_head(p1, -1, 0);
    i_Rx_Byte = 8'h0E; i_Rx_DV = 1'b1;
    tick();
    i_Rx_DV = 1'b0;
    check("t1_valid", 32'(o_Pt_Valid), 32'd1);
    check("t1_x", 32'(o_Pt_X), 32'h123);
    check("t1_y", 32'(o_Pt_Y), 32'h456);
    check("t1_count", 32'(o_Frame_Count), 32'd1);
    tick();
    check("t1_valid_clears", 32'(o_Pt_Valid), 32'd0);
    check("t1_no_err", 32'(err_seen), 32'd0);
    check("t1_no_ovf", 32'(ovf_seen), 32'd0);

    // Bad checksum, noise, then a frame whose payload is full of sync values.
    send_frame(p1, 1'b1, -1, 0, 1'b0);
    check("t2_bad_err", 32'(err_seen), 32'd1);
    check("t2_bad_count", 32'(o_Frame_Count), 32'd1);
    send_byte(8'h00);
    send_byte(8'hFF);
    sb.push_back(p2);
    send_frame(p2, 1'b0, -1, 0, 1'b0);
    check("t2_resync_count", 32'(o_Frame_Count), 32'd2);
    check("t2_noise_no_err", 32'(err_seen), 32'd1);
    check("t2_drained", 32'(sb.size()), 32'd0);

    // Timeout after A5 12 34, then a clean frame.
    send_byte(SYNC);
    send_byte(8'h12);
    send_byte(8'h34);
    repeat (T) tick();
    check("t3_timeout_err", 32'(err_seen), 32'd2);
    sb.push_back(p3);
    send_frame(p3, 1'b0, -1, 0, 1'b0);
    check("t3_after_count", 32'(o_Frame_Count), 32'd3);

    // Next strobe exactly TIMEOUT_CLKS clocks after the previous one: accepted.
    sb.push_back(p4);
    send_frame(p4, 1'b0, 1, T - 2, 1'b0);
    check("t3_edge_count", 32'(o_Frame_Count), 32'd4);
    check("t3_edge_no_err", 32'(err_seen), 32'd2);

    // Backpressure: first point held, second dropped with an overflow pulse.
    i_Pt_Ready = 1'b0;
    sb.push_back(p1);
    send_frame(p1, 1'b0, -1, 0, 1'b0);
    send_frame(p5, 1'b0, -1, 0, 1'b0);
    check("t4_ovf", 32'(ovf_seen), 32'd1);
    check("t4_count", 32'(o_Frame_Count), 32'd5);
    check("t4_held_valid", 32'(o_Pt_Valid), 32'd1);
    check("t4_held_x", 32'(o_Pt_X), 32'h123);
    check("t4_no_err", 32'(err_seen), 32'd2);
    i_Pt_Ready = 1'b1;
    tick();
    i_Pt_Ready = 1'b0;
    tick();
    check("t4_accepted_once", 32'(o_Pt_Valid), 32'd0);
    check("t4_drained", 32'(sb.size()), 32'd0);

    // Accept-and-reload in the checksum cycle.
    sb.push_back(p6);
    send_frame(p6, 1'b0, -1, 0, 1'b0);
    o0 = ovf_seen;
    sb.push_back(p7);
    send_frame(p7, 1'b0, -1, 0, 1'b1);
    check("t5_valid", 32'(o_Pt_Valid), 32'd1);
    check("t5_x", 32'(o_Pt_X), 32'hFFF);
    check("t5_count", 32'(o_Frame_Count), 32'd7);
    check("t5_no_ovf", 32'(ovf_seen - o0), 32'd0);
    check("t5_old_popped", 32'(sb.size()), 32'd1);
    i_Pt_Ready = 1'b1;
    tick();
    i_Pt_Ready = 1'b0;
    tick();
    check("t5_drained", 32'(sb.size()), 32'd0);

    // Reset mid-frame while a point is held.
    sb.push_back(p8);
    send_frame(p8, 1'b0, -1, 0, 1'b0);
    check("t6_held", 32'(o_Pt_Valid), 32'd1);
    send_byte(SYNC);
    send_byte(8'h12);
    send_byte(8'h34);
    i_Rst_L = 1'b0;
    tick();
    check_all_zero("t6_reset");
    sb.delete();
    i_Rst_L = 1'b1;
    e0 = err_seen;
    o0 = ovf_seen;
    send_byte(8'h56);
    send_byte(8'hFF);
    send_byte(8'h80);
    send_byte(8'h01);
    send_byte(8'h0E);
    check("t6_orphan_ignored", 32'(o_Frame_Count), 32'd0);
    i_Pt_Ready = 1'b1;
    sb.push_back(p9);
    send_frame(p9, 1'b0, -1, 0, 1'b0);
    sb.push_back(p10);
    send_frame(p10, 1'b0, -1, 0, 1'b0);
    check("t6_count", 32'(o_Frame_Count), 32'd2);
    check("t6_no_err", 32'(err_seen - e0), 32'd0);
    check("t6_no_ovf", 32'(ovf_seen - o0), 32'd0);
    check("t6_drained", 32'(sb.size()), 32'd0);

    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
